// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter.
// Contents:
//   mode_t      - 2-bit operation select type
//   MODE_*      - operation encodings for the mode input
package tff_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD   = 2'b00;
    localparam mode_t MODE_TOGGLE = 2'b01;
    localparam mode_t MODE_UP     = 2'b10;
    localparam mode_t MODE_DOWN   = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop storage cell.
// Ports:
//   clk   - clock, state changes on rising edge
//   reset - asynchronous active-low reset, clears q
//   t     - toggle request; q inverts on the next edge when high
//   q     - stored bit
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_counter.sv
// Multi-mode counter built from T flip-flops: hold, per-bit toggle, modulo up, modulo down,
// with synchronous parallel load and a registered terminal-count pulse.
// Ports:
//   clk     - clock, all state changes on rising edge
//   reset   - asynchronous active-low reset, clears q and tc
//   enabled - advance enable for the selected mode
//   mode    - 00 hold, 01 toggle, 10 up, 11 down
//   load    - synchronous load strobe, highest priority
//   d       - parallel load value
//   t_mask  - per-bit toggle request for toggle mode
//   q       - counter state
//   tc      - registered terminal-count pulse, high in the cycle after a wrap
//   zero    - combinational q == 0 flag
module tff_counter
    import tff_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enabled,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] t_mask,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    // MODULUS can be 2**32, so the range compare is done in 64 bits.
    localparam logic [63:0]      MOD_LAST = 64'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] Q_LAST   = WIDTH'(MOD_LAST);

    logic [63:0]      q_wide;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t_vec;
    logic             tc_d;

    assign q_wide = 64'(q);

    always_comb begin
        q_next = q;
        tc_d   = 1'b0;
        if (load) begin
            q_next = d;
        end else if (enabled) begin
            unique case (mode)
                MODE_HOLD: begin
                    q_next = q;
                end
                MODE_TOGGLE: begin
                    q_next = q ^ t_mask;
                end
                MODE_UP: begin
                    // Last value and any out-of-range value both wrap to zero.
                    if (q_wide < MOD_LAST) begin
                        q_next = q + WIDTH'(1);
                    end else begin
                        q_next = '0;
                        tc_d   = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    // Out-of-range values simply decrement back into range.
                    if (q == '0) begin
                        q_next = Q_LAST;
                        tc_d   = 1'b1;
                    end else begin
                        q_next = q - WIDTH'(1);
                    end
                end
                default: begin
                    q_next = q;
                end
            endcase
        end
    end

    // Every update, including load, reaches the cells as a toggle vector.
    assign t_vec = q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t_vec[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc <= 1'b0;
        end else begin
            tc <= tc_d;
        end
    end

    assign zero = (q == '0);

endmodule

// File: tb/tb_tff_counter.sv
module tb_tff_counter;
    import tff_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enabled;
    logic [1:0] mode;
    logic       load;
    logic [3:0] d;
    logic [3:0] t_mask;

    logic [3:0] q16, q10, q2;
    logic       tc16, tc10, tc2;
    logic       z16, z10, z2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4)) dut16 (
        .clk(clk), .reset(reset), .enabled(enabled), .mode(mode), .load(load),
        .d(d), .t_mask(t_mask), .q(q16), .tc(tc16), .zero(z16)
    );

    tff_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .reset(reset), .enabled(enabled), .mode(mode), .load(load),
        .d(d), .t_mask(t_mask), .q(q10), .tc(tc10), .zero(z10)
    );

    tff_counter #(.WIDTH(4), .MODULUS(2)) dut2 (
        .clk(clk), .reset(reset), .enabled(enabled), .mode(mode), .load(load),
        .d(d), .t_mask(t_mask), .q(q2), .tc(tc2), .zero(z2)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        enabled = 1'b0;
        mode    = MODE_HOLD;
        load    = 1'b0;
        d       = 4'h0;
        t_mask  = 4'h0;

        // Reset state
        #2;
        chk("rst_q", q16, 4'h0);
        chk("rst_tc", {3'b0, tc16}, 4'h0);
        chk("rst_zero", {3'b0, z16}, 4'h1);
        step();
        step();

        // Release reset, count up 17 edges
        reset   = 1'b1;
        enabled = 1'b1;
        mode    = MODE_UP;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("up16_q_%0d", k), q16, 4'(k % 16));
            chk($sformatf("up16_tc_%0d", k), {3'b0, tc16}, {3'b0, k == 16});
            chk($sformatf("up10_q_%0d", k), q10, 4'(k % 10));
            chk($sformatf("up10_tc_%0d", k), {3'b0, tc10}, {3'b0, (k % 10) == 0});
            chk($sformatf("up2_q_%0d", k), q2, 4'(k % 2));
            chk($sformatf("up2_tc_%0d", k), {3'b0, tc2}, {3'b0, (k % 2) == 0});
        end
        chk("nonzero_flag", {3'b0, z16}, 4'h0);

        // Enable low holds q, tc low
        enabled = 1'b0;
        step();
        chk("hold_dis_q16", q16, 4'h1);
        chk("hold_dis_q10", q10, 4'h7);
        chk("hold_dis_tc2", {3'b0, tc2}, 4'h0);

        // Down from zero with modulus 10
        load = 1'b1;
        d    = 4'h0;
        step();
        chk("load0_q10", q10, 4'h0);
        load    = 1'b0;
        enabled = 1'b1;
        mode    = MODE_DOWN;
        step();
        chk("dn10_q_1", q10, 4'h9);
        chk("dn10_tc_1", {3'b0, tc10}, 4'h1);
        chk("dn16_q_1", q16, 4'hF);
        chk("dn16_tc_1", {3'b0, tc16}, 4'h1);
        step();
        chk("dn10_q_2", q10, 4'h8);
        chk("dn10_tc_2", {3'b0, tc10}, 4'h0);
        step();
        chk("dn10_q_3", q10, 4'h7);
        chk("dn10_tc_3", {3'b0, tc10}, 4'h0);

        // Toggle mode
        load = 1'b1;
        d    = 4'b1010;
        step();
        chk("ld_a_q16", q16, 4'b1010);
        load   = 1'b0;
        mode   = MODE_TOGGLE;
        t_mask = 4'b0110;
        step();
        chk("tog1_q16", q16, 4'b1100);
        chk("tog1_q10", q10, 4'b1100);
        chk("tog1_tc", {3'b0, tc16}, 4'h0);
        step();
        chk("tog2_q16", q16, 4'b1010);

        // Load beats enabled UP at q=F
        load = 1'b1;
        d    = 4'hF;
        mode = MODE_UP;
        step();
        chk("ld_f_q16", q16, 4'hF);
        d = 4'h7;
        step();
        chk("prio_q16", q16, 4'h7);
        chk("prio_tc16", {3'b0, tc16}, 4'h0);

        // Out-of-range values with modulus 10
        d = 4'd12;
        step();
        load = 1'b0;
        mode = MODE_UP;
        step();
        chk("oor_up_q10", q10, 4'h0);
        chk("oor_up_tc10", {3'b0, tc10}, 4'h1);
        load = 1'b1;
        step();
        load = 1'b0;
        mode = MODE_DOWN;
        step();
        chk("oor_dn_q10", q10, 4'd11);
        chk("oor_dn_tc10", {3'b0, tc10}, 4'h0);

        // Enabled HOLD
        mode = MODE_HOLD;
        step();
        chk("hold_en_q10", q10, 4'd11);
        chk("hold_en_tc10", {3'b0, tc10}, 4'h0);

        // Async reset mid-count at q=5; dut2 wraps from 4 so its tc is high
        load = 1'b1;
        d    = 4'h4;
        step();
        load = 1'b0;
        mode = MODE_UP;
        step();
        chk("pre_rst_q16", q16, 4'h5);
        chk("pre_rst_tc2", {3'b0, tc2}, 4'h1);
        #2;
        reset = 1'b0;
        load  = 1'b1;
        d     = 4'hF;
        #1;
        chk("arst_q16", q16, 4'h0);
        chk("arst_tc16", {3'b0, tc16}, 4'h0);
        chk("arst_tc2", {3'b0, tc2}, 4'h0);
        chk("arst_zero16", {3'b0, z16}, 4'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_hold_q16_%0d", k), q16, 4'h0);
            chk($sformatf("rst_hold_z10_%0d", k), {3'b0, z10}, 4'h1);
        end

        // First edge after release evaluates normally
        reset = 1'b1;
        load  = 1'b0;
        step();
        chk("post_rst_q16", q16, 4'h1);
        chk("post_rst_q10", q10, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
